// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core: FSM state encodings,
// parity mode encodings and the oversampling ratio.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'd0,
    PAR_EVEN     = 2'd1,
    PAR_ODD      = 2'd2,
    PAR_NONE_ALT = 2'd3
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_core_p_if.sv
// Host-side FIFO access bundle of the UART core: TX push and RX pop.
interface uart_core_p_if #(parameter int DATA_BITS = 8);

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 tx_full;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rx_empty;

  modport master (output wr_en, wr_data, rd_en, input tx_full, rd_data, rx_empty);
  modport slave  (input wr_en, wr_data, rd_en, output tx_full, rd_data, rx_empty);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a registered read port.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  // Full blocks writes even when a read happens in the same cycle.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      rd_data    <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) begin
        rd_data    <= mem[rd_ptr_reg[AW-1:0]];
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_core_p.sv
// UART core: shared baud tick, TX and RX FSMs with 16x oversampling,
// one FIFO per direction and sticky receive error flags.
module uart_core_p
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] dvsr,
  input  logic [1:0]  parity_mode,
  input  logic        two_stop,
  input  logic        clr_err,
  input  logic        rx,
  output logic        tx,
  output logic        tx_busy,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun,
  uart_core_p_if.slave bus
);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic [10:0] tick_cnt_reg;
  logic        tick;

  assign tick = (tick_cnt_reg == dvsr);

  // Wrap on >= so a dvsr lowered below the running count restarts at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_reg <= '0;
    else        tick_cnt_reg <= (tick_cnt_reg >= dvsr) ? '0 : tick_cnt_reg + 11'd1;
  end

  logic [DATA_BITS-1:0] tx_fifo_data;
  logic                 tx_fifo_empty;
  logic                 tx_pop_reg;
  logic                 rx_push_reg;
  logic                 rx_fifo_full;
  logic [DATA_BITS-1:0] rx_shift_reg;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en(bus.wr_en), .wr_data(bus.wr_data),
    .rd_en(tx_pop_reg), .rd_data(tx_fifo_data),
    .full(bus.tx_full), .empty(tx_fifo_empty)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en(rx_push_reg), .wr_data(rx_shift_reg),
    .rd_en(bus.rd_en), .rd_data(bus.rd_data),
    .full(rx_fifo_full), .empty(bus.rx_empty)
  );

  tx_state_t            tx_state_reg;
  logic [3:0]           tx_tick_reg;
  logic [2:0]           tx_bit_reg;
  logic [DATA_BITS-1:0] tx_word_reg;
  parity_t              tx_mode_reg;
  logic                 tx_two_stop_reg;
  logic                 tx_stop2_reg;
  logic                 tx_bit_done;

  assign tx_bit_done = tick && (tx_tick_reg == LAST_TICK);
  assign tx_busy     = (tx_state_reg != TX_IDLE);

  // Popped word lands two clocks after the pop decision, long before START ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg    <= TX_IDLE;
      tx              <= 1'b1;
      tx_tick_reg     <= '0;
      tx_bit_reg      <= '0;
      tx_word_reg     <= '0;
      tx_mode_reg     <= PAR_NONE;
      tx_two_stop_reg <= 1'b0;
      tx_stop2_reg    <= 1'b0;
      tx_pop_reg      <= 1'b0;
    end else begin
      tx_pop_reg <= 1'b0;
      if (tick) tx_tick_reg <= tx_tick_reg + 4'd1;
      case (tx_state_reg)
        TX_IDLE: begin
          tx          <= 1'b1;
          tx_tick_reg <= '0;
          if (tick && !tx_fifo_empty) begin
            tx_pop_reg      <= 1'b1;
            tx_mode_reg     <= parity_t'(parity_mode);
            tx_two_stop_reg <= two_stop;
            tx              <= 1'b0;
            tx_state_reg    <= TX_START;
          end
        end
        TX_START: if (tx_bit_done) begin
          tx_word_reg  <= tx_fifo_data;
          tx           <= tx_fifo_data[0];
          tx_bit_reg   <= '0;
          tx_stop2_reg <= 1'b0;
          tx_state_reg <= TX_DATA;
        end
        TX_DATA: if (tx_bit_done) begin
          if (tx_bit_reg == LAST_BIT) begin
            if (parity_on(tx_mode_reg)) begin
              tx           <= (^tx_word_reg) ^ (tx_mode_reg == PAR_ODD);
              tx_state_reg <= TX_PARITY;
            end else begin
              tx           <= 1'b1;
              tx_state_reg <= TX_STOP;
            end
          end else begin
            tx         <= tx_word_reg[tx_bit_reg + 3'd1];
            tx_bit_reg <= tx_bit_reg + 3'd1;
          end
        end
        TX_PARITY: if (tx_bit_done) begin
          tx           <= 1'b1;
          tx_state_reg <= TX_STOP;
        end
        TX_STOP: if (tx_bit_done) begin
          if (tx_two_stop_reg && !tx_stop2_reg) begin
            tx_stop2_reg <= 1'b1;
          end else if (!tx_fifo_empty) begin
            tx_pop_reg      <= 1'b1;
            tx_mode_reg     <= parity_t'(parity_mode);
            tx_two_stop_reg <= two_stop;
            tx              <= 1'b0;
            tx_state_reg    <= TX_START;
          end else begin
            tx           <= 1'b1;
            tx_state_reg <= TX_IDLE;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  logic       rx_meta_reg;
  logic       rx_sync_reg;
  rx_state_t  rx_state_reg;
  logic [3:0] rx_tick_reg;
  logic [2:0] rx_bit_reg;
  parity_t    rx_mode_reg;
  logic       rx_bit_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  assign rx_bit_done = tick && (rx_tick_reg == LAST_TICK);

  // Clear first so an error raised in the same cycle still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg <= RX_IDLE;
      rx_tick_reg  <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_mode_reg  <= PAR_NONE;
      rx_push_reg  <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rx_push_reg <= 1'b0;
      if (clr_err) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
      if (rx_push_reg && rx_fifo_full) overrun <= 1'b1;
      if (tick) rx_tick_reg <= rx_tick_reg + 4'd1;
      case (rx_state_reg)
        RX_IDLE: begin
          rx_tick_reg <= '0;
          if (!rx_sync_reg) begin
            rx_mode_reg  <= parity_t'(parity_mode);
            rx_state_reg <= RX_START;
          end
        end
        RX_START: if (tick && rx_tick_reg == MID_TICK) begin
          rx_tick_reg  <= '0;
          rx_bit_reg   <= '0;
          rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_bit_done) begin
          rx_shift_reg <= {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
          rx_bit_reg   <= rx_bit_reg + 3'd1;
          if (rx_bit_reg == LAST_BIT)
            rx_state_reg <= parity_on(rx_mode_reg) ? RX_PARITY : RX_STOP;
        end
        RX_PARITY: if (rx_bit_done) begin
          if (rx_sync_reg != ((^rx_shift_reg) ^ (rx_mode_reg == PAR_ODD)))
            parity_err <= 1'b1;
          rx_state_reg <= RX_STOP;
        end
        RX_STOP: if (rx_bit_done) begin
          if (!rx_sync_reg) frame_err <= 1'b1;
          rx_push_reg  <= 1'b1;
          rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core_p.sv
// Self-checking bench for uart_core_p: table vectors and random frames in
// loopback, raw-driven error/glitch frames, overrun and mid-frame reset.
module tb_uart_core_p;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] dvsr = 11'd1;
  logic [1:0]  parity_mode = 2'd0;
  logic        two_stop = 1'b0;
  logic        clr_err = 1'b0;
  logic        rx;
  logic        tx, tx_busy, parity_err, frame_err, overrun;
  logic        loop_en = 1'b1;
  logic        rx_drv = 1'b1;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  w [16];

  uart_core_p_if #(.DATA_BITS(DB)) bus();

  assign rx = loop_en ? tx : rx_drv;

  uart_core_p #(.DATA_BITS(DB), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .dvsr(dvsr), .parity_mode(parity_mode),
    .two_stop(two_stop), .clr_err(clr_err), .rx(rx), .tx(tx),
    .tx_busy(tx_busy), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pm;
    logic        ts;
    logic [10:0] dv;
    logic        has_par;
    logic        exp_par;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic cur(input int sel);
    case (sel)
      0:       return tx;
      1:       return tx_busy;
      default: return bus.rx_empty;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int bound,
                          input string name, output logic ok);
    int k = 0;
    while (cur(sel) !== val && k < bound) begin
      @(negedge clk);
      k++;
    end
    ok = (cur(sel) === val);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: timeout after %0d cycles, signal never reached %0b", name, bound, val);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pop(output logic [7:0] d);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.rd_data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bit(s).
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic [1:0] pm,
                                             input logic ts, output int n);
    logic [15:0] f = '0;
    n = 0;
    f[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin f[n] = d[i]; n++; end
    if (pm == 2'd1 || pm == 2'd2) begin
      f[n] = (^d) ^ (pm == 2'd2); n++;
    end
    f[n] = 1'b1; n++;
    if (ts) begin f[n] = 1'b1; n++; end
    return f;
  endfunction

  task automatic drive_bits(input logic [15:0] b, input int n, input int last_ticks);
    int bt = int'(dvsr) + 1;
    for (int i = 0; i < n; i++) begin
      rx_drv = b[i];
      cycles(((i == n - 1) ? last_ticks : 16) * bt);
    end
    rx_drv = 1'b1;
  endtask

  task automatic send_check(input logic [7:0] d, input logic [1:0] pm, input logic ts,
                            input logic [10:0] dv, input logic has_par, input logic exp_par);
    logic [15:0] f;
    logic        rec [2048];
    logic        ok;
    logic [7:0]  got;
    int          n, bt, lead, run;
    dvsr = dv; parity_mode = pm; two_stop = ts; loop_en = 1'b1;
    f  = frame_bits(d, pm, ts, n);
    bt = 16 * (int'(dv) + 1);
    push(d);
    wait_sig(0, 1'b0, 2 * bt + 20, "tx_start_fall", ok);
    if (!ok) return;
    for (int t = 0; t < n * bt; t++) begin
      rec[t] = tx;
      @(negedge clk);
    end
    lead = 0;
    while (lead < n && f[lead] == 1'b0) lead++;
    run = 0;
    while (run < n * bt && rec[run] == 1'b0) run++;
    check("tx_low_run_clocks", run, lead * bt);
    for (int i = 0; i < n; i++)
      check($sformatf("tx_bit%0d", i), rec[(16 * i + 8) * (int'(dv) + 1)], f[i]);
    if (has_par) check("tx_parity_bit", rec[(16 * 9 + 8) * (int'(dv) + 1)], exp_par);
    wait_sig(2, 1'b0, 400, "rx_word_arrives", ok);
    pop(got);
    check("rx_data", got, d);
    check("rx_err_flags", {parity_err, frame_err, overrun}, 3'b000);
    wait_sig(1, 1'b0, 2 * bt + 20, "tx_back_idle", ok);
    $display("[TB] frame data=%02h pm=%0d two_stop=%0b dvsr=%0d got=%02h", d, pm, ts, dv, got);
  endtask

  initial begin
    vec_t        vecs [6];
    logic [15:0] f;
    logic [7:0]  got;
    logic        ok;
    int          n;

    vecs[0] = '{8'hA5, 2'd0, 1'b0, 11'd1, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 2'd1, 1'b0, 11'd1, 1'b1, 1'b1};
    vecs[2] = '{8'h07, 2'd2, 1'b0, 11'd1, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 2'd3, 1'b1, 11'd0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 2'd2, 1'b1, 11'd2, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 2'd1, 1'b0, 11'd0, 1'b1, 1'b0};

    bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
    cycles(3);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_tx_full", bus.tx_full, 1'b0);
    check("rst_rx_empty", bus.rx_empty, 1'b1);
    check("rst_rd_data", bus.rd_data, 8'h00);
    check("rst_err_flags", {parity_err, frame_err, overrun}, 3'b000);
    rst_n = 1'b1;
    cycles(2);

    for (int i = 0; i < 6; i++)
      send_check(vecs[i].data, vecs[i].pm, vecs[i].ts, vecs[i].dv, vecs[i].has_par, vecs[i].exp_par);

    for (int i = 0; i < 10; i++)
      send_check(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 11'($urandom_range(0, 3)), 1'b0, 1'b0);

    // Raw frame with a wrong parity bit.
    loop_en = 1'b0; dvsr = 11'd1; parity_mode = 2'd1; two_stop = 1'b0;
    f = frame_bits(8'h07, 2'd1, 1'b0, n);
    f[9] = ~f[9];
    drive_bits(f, n, 16);
    cycles(20);
    check("par_err_word_pushed", bus.rx_empty, 1'b0);
    pop(got);
    check("par_err_data", got, 8'h07);
    check("par_err_flags", {parity_err, frame_err}, 2'b10);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("par_err_cleared", parity_err, 1'b0);
    $display("[TB] raw parity-error frame data=07 got=%02h", got);

    // Raw frame with a stop bit of 0, released after 12 ticks.
    parity_mode = 2'd0;
    f = frame_bits(8'h3C, 2'd0, 1'b0, n);
    f[n - 1] = 1'b0;
    drive_bits(f, n, 12);
    cycles(60);
    check("frame_err_word_pushed", bus.rx_empty, 1'b0);
    pop(got);
    check("frame_err_data", got, 8'h3C);
    check("frame_err_flags", {parity_err, frame_err}, 2'b01);
    check("frame_err_no_extra_word", bus.rx_empty, 1'b1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("frame_err_cleared", frame_err, 1'b0);
    $display("[TB] raw framing-error frame data=3C got=%02h", got);

    // Short low glitch must not start a frame; a good frame afterwards must.
    f = 16'h0000;
    drive_bits(f, 1, 4);
    cycles(16 * 12 * 2);
    check("glitch_no_word", bus.rx_empty, 1'b1);
    check("glitch_no_err", {parity_err, frame_err, overrun}, 3'b000);
    f = frame_bits(8'h5A, 2'd0, 1'b0, n);
    drive_bits(f, n, 16);
    cycles(20);
    check("post_glitch_word", bus.rx_empty, 1'b0);
    pop(got);
    check("post_glitch_data", got, 8'h5A);
    $display("[TB] glitch then raw frame data=5A got=%02h", got);

    // Overrun: fill TX at a slow baud, then run 16 + 1 frames without reads.
    rst_n = 1'b0; dvsr = 11'd100; parity_mode = 2'd0; two_stop = 1'b0; loop_en = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w[i] = 8'($urandom_range(0, 255));
      push(w[i]);
    end
    check("tx_full_after_16", bus.tx_full, 1'b1);
    push(8'hEE);
    check("tx_full_after_17th", bus.tx_full, 1'b1);
    dvsr = 11'd0;
    wait_sig(1, 1'b1, 20, "ovr_tx_start", ok);
    wait_sig(1, 1'b0, 4000, "ovr_tx_drain", ok);
    check("ovr_rx_nonempty", bus.rx_empty, 1'b0);
    check("ovr_not_yet", overrun, 1'b0);
    push(8'h99);
    wait_sig(1, 1'b1, 20, "ovr17_tx_start", ok);
    wait_sig(1, 1'b0, 400, "ovr17_tx_done", ok);
    cycles(5);
    check("overrun_set", overrun, 1'b1);
    for (int i = 0; i < 16; i++) begin
      pop(got);
      check($sformatf("ovr_read%0d", i), got, w[i]);
    end
    check("ovr_17th_lost", bus.rx_empty, 1'b1);
    pop(got);
    check("pop_empty_holds", got, w[15]);
    $display("[TB] overrun sequence: 16 words read back, last=%02h", got);

    // Reset in the middle of a start bit with a full TX FIFO.
    dvsr = 11'd20;
    for (int i = 0; i < 17; i++) push(8'($urandom_range(0, 255)));
    check("mid_tx_full", bus.tx_full, 1'b1);
    wait_sig(0, 1'b0, 800, "mid_tx_fall", ok);
    cycles(100);
    check("pre_reset_tx", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_tx_full", bus.tx_full, 1'b0);
    check("async_rst_tx_busy", tx_busy, 1'b0);
    check("async_rst_rx_empty", bus.rx_empty, 1'b1);
    check("async_rst_rd_data", bus.rd_data, 8'h00);
    check("async_rst_flags", {parity_err, frame_err, overrun}, 3'b000);
    @(negedge clk);
    dvsr = 11'd0;
    rst_n = 1'b1;
    cycles(400);
    check("post_reset_no_word", bus.rx_empty, 1'b1);
    check("post_reset_tx_idle", {tx, tx_busy}, 2'b10);
    $display("[TB] mid-frame reset: tx=%0b tx_full=%0b", tx, bus.tx_full);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_core_p.md
UART_CORE_P -- requirements
Module: uart_core_p

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, legal 5..8, character width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, power of 2 from 4 to 64, depth of each of the TX and RX FIFOs.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: dvsr  in  11  baud divisor; one oversample tick every dvsr+1 clocks.
REQ-006 Port: parity_mode  in  2  0 = none, 1 = even, 2 = odd, 3 = none.
REQ-007 Port: two_stop  in  1  1 = TX sends 2 stop bits.
REQ-008 Port: wr_en / wr_data  in  1 / DATA_BITS  TX FIFO push.
REQ-009 Port: tx_full  out  1  TX FIFO full.
REQ-010 Port: rd_en  in  1  RX FIFO pop.
REQ-011 Port: rd_data  out  DATA_BITS  popped RX word.
REQ-012 Port: rx_empty  out  1  RX FIFO empty.
REQ-013 Port: tx  out  1  serial out, idle high.
REQ-014 Port: rx  in  1  serial in, asynchronous.
REQ-015 Port: tx_busy  out  1  TX FSM not in IDLE.
REQ-016 Port: parity_err / frame_err / overrun  out  1 each  sticky error flags.
REQ-017 Port: clr_err  in  1  one-cycle pulse clearing all three error flags.

Function
REQ-018 Tick generator SHALL count 0..dvsr and pulse tick when the count equals dvsr; dvsr = 0 gives a tick every clock; bit time SHALL be 16 ticks.
REQ-019 Frame SHALL be: start(0), DATA_BITS data bits LSB first, optional parity bit, then 1 or 2 stop(1) bits.
REQ-020 Parity bit SHALL be XOR of the data bits (even) or its inverse (odd).
REQ-021 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; in IDLE with the TX FIFO non-empty it SHALL pop one word and latch parity_mode and two_stop, then go to START.
REQ-022 Each TX state SHALL hold tx for 16 ticks; after the last stop bit TX SHALL return to IDLE, or go straight to START if the FIFO is non-empty, with no idle bit.
REQ-023 rx SHALL pass a 2-flop synchronizer before use.
REQ-024 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a low level in IDLE enters START.
REQ-025 In START, at tick 8, a high sample SHALL return the FSM to IDLE (glitch reject); a low sample SHALL enter DATA.
REQ-026 RX SHALL sample each data, parity and stop bit every 16 ticks from the mid-start point.
REQ-027 RX SHALL check one stop bit only; a stop bit sampled 0 SHALL set frame_err.
REQ-028 A parity mismatch SHALL set parity_err.
REQ-029 At the end of STOP, RX SHALL push the word into the RX FIFO even if errors were flagged; RX config SHALL be latched on entry to START.
REQ-030 If the RX FIFO is full at push, the word SHALL be dropped and overrun set.
REQ-031 When clr_err and a new error occur in the same cycle, the flag SHALL be set.
REQ-032 FIFO writes SHALL be ignored when full, even with a simultaneous read; reads SHALL be ignored when empty.
REQ-033 Pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap naturally; full = MSBs differ and the rest are equal; empty = pointers equal.
REQ-034 rd_data SHALL be registered and valid the cycle after an accepted rd_en, holding its value otherwise.
REQ-035 Changes to dvsr mid-frame SHALL take effect on the next tick count.

Reset
REQ-036 On rst_n low: tx = 1, tx_busy = 0, tx_full = 0, rx_empty = 1, rd_data = 0, all error flags = 0, both FSMs in IDLE, tick counter = 0, FIFOs emptied.
REQ-037 Reset mid-frame SHALL abort the frame immediately, discarding the partial word.

Structure
REQ-038 Package uart_pkg SHALL hold the tx/rx state enums, parity_mode encodings and the OVERSAMPLE = 16 constant.
REQ-039 Sub-module uart_sync_fifo (parameters WIDTH and DEPTH) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-040 dvsr=1, parity 0, tx looped to rx, write 0xA5 -> tx low for 32 clocks then 1,0,1,0,0,1,0,1; rx_empty falls; rd_data = 0xA5; no error flags.
REQ-041 parity_mode=1, write 0x07 -> parity bit 1; parity_mode=2 -> parity bit 0; loopback shows no parity_err.
REQ-042 Drive rx with a stop bit of 0 -> frame_err = 1, word still pushed; clr_err pulse -> frame_err = 0.
REQ-043 Receive 17 frames with no reads (depth 16) -> overrun = 1; 16 words are read back in order; 17th word lost.
REQ-044 rx low pulse of 4 ticks -> no word received, RX FSM back in IDLE.
REQ-045 Write 16 words at dvsr=100 -> tx_full = 1; 17th write ignored; rst_n low mid-frame -> tx = 1 and tx_full = 0 in the same cycle.
